// File: rtl/access_requester.sv
// access_requester: drives the request/confirm handshake toward the lock
// controller, waits for a route grant, and locks out after MAX_TRIES
// consecutive failures. Every output is a flop loaded from next-state logic.
module access_requester #(
    parameter int TIMEOUT   = 8,   // WAIT cycles allowed for a grant (2..255)
    parameter int MAX_TRIES = 3    // consecutive failures before lockout (1..3)
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       abort,
    input  logic       unlock,
    input  logic [3:0] user_pass,
    input  logic [3:0] user_data,
    input  logic       en_left,
    input  logic       en_right,
    input  logic [3:0] dout_in,
    output logic       request,
    output logic       confirm,
    output logic [3:0] pass_data,
    output logic [3:0] din,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic       side,
    output logic [3:0] rx_data,
    output logic [1:0] attempts,
    output logic       locked
);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_PCONF, S_PGAP, S_DCONF, S_WAIT, S_DONE, S_FAIL, S_LOCK
    } state_t;

    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [1:0] TRIES_MAX = 2'(MAX_TRIES);

    state_t     state, state_nxt;
    logic [3:0] pass_q, data_q, pass_nxt, data_nxt;
    logic [7:0] timer;
    logic       in_flight, grant, clash, expire;
    logic       req_nxt, cnf_nxt, busy_nxt, capture;
    logic [1:0] att_inc;

    // Next-state and next-output decode; abort overrides every in-flight decision.
    always_comb begin
        state_nxt = state;
        pass_nxt  = pass_q;
        data_nxt  = data_q;
        grant     = en_left ^ en_right;
        clash     = en_left & en_right;
        expire    = (timer == TO_LAST);
        // DONE/FAIL have already resolved the transaction, so abort is
        // honoured only while the handshake is still outstanding.
        in_flight = (state == S_REQ) || (state == S_PCONF) || (state == S_PGAP) ||
                    (state == S_DCONF) || (state == S_WAIT);
        case (state)
            S_IDLE: if (start) begin
                state_nxt = S_REQ;
                pass_nxt  = user_pass;
                data_nxt  = user_data;
            end
            S_REQ:   state_nxt = S_PCONF;
            S_PCONF: state_nxt = S_PGAP;
            S_PGAP:  state_nxt = S_DCONF;
            S_DCONF: state_nxt = S_WAIT;
            S_WAIT: begin
                if (clash)       state_nxt = S_FAIL;
                else if (grant)  state_nxt = S_DONE;
                else if (expire) state_nxt = S_FAIL;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_FAIL:  state_nxt = (attempts == TRIES_MAX) ? S_LOCK : S_IDLE;
            S_LOCK:  if (unlock) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (in_flight && abort) state_nxt = S_IDLE;

        req_nxt  = (state_nxt == S_REQ) || (state_nxt == S_PCONF) || (state_nxt == S_PGAP) ||
                   (state_nxt == S_DCONF) || (state_nxt == S_WAIT);
        cnf_nxt  = (state_nxt == S_PCONF) || (state_nxt == S_DCONF);
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_LOCK);
        capture  = (state == S_WAIT) && (state_nxt == S_DONE);
        att_inc  = (attempts == 2'd3) ? 2'd3 : attempts + 2'd1;
    end

    // State, latched operands, WAIT timer and all registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pass_q    <= '0;
            data_q    <= '0;
            timer     <= '0;
            request   <= 1'b0;
            confirm   <= 1'b0;
            pass_data <= '0;
            din       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            side      <= 1'b0;
            rx_data   <= '0;
            attempts  <= '0;
            locked    <= 1'b0;
        end else begin
            state     <= state_nxt;
            pass_q    <= pass_nxt;
            data_q    <= data_nxt;
            timer     <= ((state == S_WAIT) && (state_nxt == S_WAIT)) ? timer + 8'd1 : 8'd0;
            request   <= req_nxt;
            confirm   <= cnf_nxt;
            pass_data <= req_nxt ? pass_nxt : 4'd0;
            din       <= ((state_nxt == S_DCONF) || (state_nxt == S_WAIT)) ? data_nxt : 4'd0;
            busy      <= busy_nxt;
            done      <= (state_nxt == S_DONE);
            fail      <= (state_nxt == S_FAIL);
            locked    <= (state_nxt == S_LOCK);
            if (capture) begin
                rx_data <= dout_in;
                side    <= en_left;
            end
            if (state_nxt == S_DONE)
                attempts <= 2'd0;
            else if (state_nxt == S_FAIL)
                attempts <= att_inc;
            else if ((state == S_LOCK) && unlock)
                attempts <= 2'd0;
        end
    end

endmodule
